// File: rtl/input_frame_pkg.sv
// Shared definitions for the ping-pong input sample RAM controller.
package input_frame_pkg;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_ADDR_BITS  = 10;
  localparam int DEF_RD_LATENCY = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Words per RAM half: the top address bit selects the half.
  function automatic int halfWords(input int addrBits);
    return 1 << (addrBits - 1);
  endfunction

endpackage

// File: rtl/frame_rd_pipe.sv
// Delays the read-issue and last-address strobes by RD_LATENCY cycles to align with RamDoutB.
// No backpressure: one strobe in per cycle, one out per cycle.
module frame_rd_pipe #(
  parameter int RD_LATENCY = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Issue,
  input  logic IssueLast,
  output logic RdValid,
  output logic RdLast
);

  logic [RD_LATENCY-1:0] validPipe;
  logic [RD_LATENCY-1:0] lastPipe;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      validPipe <= '0;
      lastPipe  <= '0;
    end else begin
      validPipe[0] <= Issue;
      lastPipe[0]  <= IssueLast;
      for (int i = 1; i < RD_LATENCY; i++) begin
        validPipe[i] <= validPipe[i-1];
        lastPipe[i]  <= lastPipe[i-1];
      end
    end
  end

  assign RdValid = validPipe[RD_LATENCY-1];
  assign RdLast  = lastPipe[RD_LATENCY-1];

endmodule

// File: rtl/input_frame_ctrl.sv
// Ping-pong controller: port A streams ADC samples into one RAM half, port B plays a full half to the FFT.
// Read data trails its address by RD_LATENCY; samples hitting a full half are dropped and flagged sticky.
module input_frame_ctrl
  import input_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] SampleIn,
  input  logic                  SampleValid,
  input  logic                  FrameReq,
  output logic                  FrameAvail,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdValid,
  output logic                  RdLast,
  output logic                  Overrun,
  input  logic                  OverrunClr,
  output logic                  RamEnA,
  output logic                  RamWeA,
  output logic [ADDR_BITS-1:0]  RamAddrA,
  output logic [DATA_WIDTH-1:0] RamDinA,
  output logic                  RamEnB,
  output logic                  RamWeB,
  output logic [ADDR_BITS-1:0]  RamAddrB,
  input  logic [DATA_WIDTH-1:0] RamDoutB
);

  localparam int HALF       = halfWords(ADDR_BITS);
  localparam int CNT_BITS   = ADDR_BITS - 1;
  localparam int DRAIN_BITS = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_BITS-1:0]   LAST_IDX  = CNT_BITS'(HALF - 1);
  localparam logic [DRAIN_BITS-1:0] DRAIN_END = DRAIN_BITS'(RD_LATENCY - 1);

  logic                  wrHalf;
  logic [CNT_BITS-1:0]   wrCnt;
  logic                  rdHalf;
  logic [CNT_BITS-1:0]   rdCnt;
  logic [1:0]            fullFlags;
  logic [1:0]            rdState;
  logic [DRAIN_BITS-1:0] drainCnt;

  logic       wrAccept;
  logic       wrDrop;
  logic       drainDone;
  logic       issue;
  logic       issueLast;
  logic       pipeValid;
  logic       pipeLast;
  logic [1:0] setMask;
  logic [1:0] clrMask;

  assign wrAccept  = SampleValid & ~fullFlags[wrHalf];
  assign wrDrop    = SampleValid &  fullFlags[wrHalf];
  assign issue     = (rdState == ST_READ);
  assign issueLast = issue && (rdCnt == LAST_IDX);
  assign drainDone = (rdState == ST_DRAIN) && (drainCnt == DRAIN_END);

  assign FrameAvail = fullFlags[rdHalf];
  assign RamAddrA   = {wrHalf, wrCnt};
  assign RamAddrB   = {rdHalf, rdCnt};
  assign RamWeB     = 1'b0;

  // Write side: address now, enable and data one cycle later.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wrHalf  <= 1'b0;
      wrCnt   <= '0;
      RamEnA  <= 1'b0;
      RamWeA  <= 1'b0;
      RamDinA <= '0;
      Overrun <= 1'b0;
    end else begin
      RamEnA <= wrAccept;
      RamWeA <= wrAccept;
      if (wrAccept) begin
        RamDinA <= SampleIn;
        if (wrCnt == LAST_IDX) begin
          wrCnt  <= '0;
          wrHalf <= ~wrHalf;
        end else begin
          wrCnt <= wrCnt + CNT_BITS'(1);
        end
      end
      if (wrDrop) begin
        Overrun <= 1'b1;
      end else if (OverrunClr) begin
        Overrun <= 1'b0;
      end
    end
  end

  // Set and clear always target opposite halves, so both apply in the same cycle.
  always_comb begin
    setMask = 2'b00;
    clrMask = 2'b00;
    if (wrAccept && (wrCnt == LAST_IDX)) setMask[wrHalf] = 1'b1;
    if (drainDone) clrMask[rdHalf] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fullFlags <= 2'b00;
    end else begin
      fullFlags <= (fullFlags | setMask) & ~clrMask;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdState  <= ST_IDLE;
      rdHalf   <= 1'b0;
      rdCnt    <= '0;
      drainCnt <= '0;
      RamEnB   <= 1'b0;
    end else begin
      RamEnB <= issue;
      case (rdState)
        ST_IDLE: begin
          if (FrameReq && FrameAvail) begin
            rdState <= ST_READ;
            rdCnt   <= '0;
          end
        end
        ST_READ: begin
          rdCnt <= rdCnt + CNT_BITS'(1);
          if (rdCnt == LAST_IDX) begin
            rdState  <= ST_DRAIN;
            drainCnt <= '0;
          end
        end
        ST_DRAIN: begin
          // Half stays full until its last word has left the RAM.
          if (drainCnt == DRAIN_END) begin
            rdState <= ST_IDLE;
            rdHalf  <= ~rdHalf;
          end else begin
            drainCnt <= drainCnt + DRAIN_BITS'(1);
          end
        end
        default: rdState <= ST_IDLE;
      endcase
    end
  end

  frame_rd_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Issue    (issue),
    .IssueLast(issueLast),
    .RdValid  (pipeValid),
    .RdLast   (pipeLast)
  );

  assign RdValid = pipeValid;
  assign RdLast  = pipeLast;
  assign RdData  = pipeValid ? RamDoutB : '0;

endmodule

// File: tb/tb_input_frame_ctrl.sv
// Directed bench for input_frame_ctrl with a registered-address dual-port RAM model (HALF=8, RD_LATENCY=2).
module tb_input_frame_ctrl;

  localparam int DW = 18;
  localparam int AB = 4;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [DW-1:0] SampleIn;
  logic          SampleValid;
  logic          FrameReq;
  logic          FrameAvail;
  logic [DW-1:0] RdData;
  logic          RdValid;
  logic          RdLast;
  logic          Overrun;
  logic          OverrunClr;
  logic          RamEnA;
  logic          RamWeA;
  logic [AB-1:0] RamAddrA;
  logic [DW-1:0] RamDinA;
  logic          RamEnB;
  logic          RamWeB;
  logic [AB-1:0] RamAddrB;
  logic [DW-1:0] RamDoutB;

  always #5 Clk = ~Clk;

  input_frame_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_BITS (AB),
    .RD_LATENCY(2)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .SampleIn   (SampleIn),
    .SampleValid(SampleValid),
    .FrameReq   (FrameReq),
    .FrameAvail (FrameAvail),
    .RdData     (RdData),
    .RdValid    (RdValid),
    .RdLast     (RdLast),
    .Overrun    (Overrun),
    .OverrunClr (OverrunClr),
    .RamEnA     (RamEnA),
    .RamWeA     (RamWeA),
    .RamAddrA   (RamAddrA),
    .RamDinA    (RamDinA),
    .RamEnB     (RamEnB),
    .RamWeB     (RamWeB),
    .RamAddrB   (RamAddrB),
    .RamDoutB   (RamDoutB)
  );

  // RAM model: address registered one cycle ahead of enable; read data lands the cycle after that.
  logic [DW-1:0] mem [16];
  logic [AB-1:0] aRegA;
  logic [AB-1:0] aRegB;
  logic [DW-1:0] doutB;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    doutB = '0;
    aRegA = '0;
    aRegB = '0;
  end

  always @(posedge Clk) begin
    aRegA <= RamAddrA;
    aRegB <= RamAddrB;
    if (RamEnA && RamWeA) mem[aRegA] <= RamDinA;
    if (RamEnB) doutB <= mem[aRegB];
  end

  assign RamDoutB = doutB;

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sin;
    logic          req;
    logic          clr;
    logic          enA;
    logic [AB-1:0] addrA;
    logic [DW-1:0] dinA;
    logic          avail;
    logic          ovr;
    logic          enB;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sv, input logic [DW-1:0] sin, input logic req,
                              input logic clr, input logic enA, input logic [AB-1:0] addrA,
                              input logic [DW-1:0] dinA, input logic avail, input logic ovr,
                              input logic enB);
    vec_t v;
    v.sv = sv; v.sin = sin; v.req = req; v.clr = clr;
    v.enA = enA; v.addrA = addrA; v.dinA = dinA;
    v.avail = avail; v.ovr = ovr; v.enB = enB;
    return v;
  endfunction

  task automatic idleInputs();
    SampleValid = 1'b0;
    SampleIn    = '0;
    FrameReq    = 1'b0;
    OverrunClr  = 1'b0;
  endtask

  task automatic doReset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    idleInputs();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst RamEnA", RamEnA, 0);
    check("rst RamWeA", RamWeA, 0);
    check("rst RamAddrA", RamAddrA, 0);
    check("rst RamDinA", RamDinA, 0);
    check("rst RamEnB", RamEnB, 0);
    check("rst RamWeB", RamWeB, 0);
    check("rst RamAddrB", RamAddrB, 0);
    check("rst RdValid", RdValid, 0);
    check("rst RdLast", RdLast, 0);
    check("rst RdData", RdData, 0);
    check("rst FrameAvail", FrameAvail, 0);
    check("rst Overrun", Overrun, 0);
    Rst_n = 1'b1;
  endtask

  task automatic runTable(input string tag);
    foreach (vecs[i]) begin
      @(posedge Clk);
      #1;
      SampleValid = vecs[i].sv;
      SampleIn    = vecs[i].sin;
      FrameReq    = vecs[i].req;
      OverrunClr  = vecs[i].clr;
      @(negedge Clk);
      check($sformatf("%s[%0d] RamEnA", tag, i), RamEnA, vecs[i].enA);
      check($sformatf("%s[%0d] RamWeA", tag, i), RamWeA, vecs[i].enA);
      check($sformatf("%s[%0d] RamAddrA", tag, i), RamAddrA, vecs[i].addrA);
      check($sformatf("%s[%0d] RamDinA", tag, i), RamDinA, vecs[i].dinA);
      check($sformatf("%s[%0d] FrameAvail", tag, i), FrameAvail, vecs[i].avail);
      check($sformatf("%s[%0d] Overrun", tag, i), Overrun, vecs[i].ovr);
      check($sformatf("%s[%0d] RamEnB", tag, i), RamEnB, vecs[i].enB);
    end
  endtask

  // Three early requests with nothing buffered, then 0x001..0x008 into half 0.
  task automatic buildFill();
    vecs.delete();
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, '0, 1, 0, 0, '0, '0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, DW'(i + 1), 0, 0, (i > 0), AB'(i), (i > 0) ? DW'(i) : DW'(0), 0, 0, 0));
    vecs.push_back(mk(0, '0, 0, 0, 1, AB'(8), DW'(8), 1, 0, 0));
    vecs.push_back(mk(0, '0, 0, 0, 0, AB'(8), DW'(8), 1, 0, 0));
  endtask

  // Both halves filled, 17th sample dropped, clear, then drop coinciding with clear.
  task automatic buildOvr();
    vecs.delete();
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1, DW'('h20 + i), 0, 0, (i > 0), AB'(i),
                        (i > 0) ? DW'('h20 + i - 1) : DW'(0), (i >= 8), 0, 0));
    vecs.push_back(mk(1, DW'('h99), 0, 0, 1, '0, DW'('h2F), 1, 0, 0));
    vecs.push_back(mk(0, '0,        0, 0, 0, '0, DW'('h2F), 1, 1, 0));
    vecs.push_back(mk(0, '0,        0, 1, 0, '0, DW'('h2F), 1, 1, 0));
    vecs.push_back(mk(0, '0,        0, 0, 0, '0, DW'('h2F), 1, 0, 0));
    vecs.push_back(mk(1, DW'('h77), 0, 1, 0, '0, DW'('h2F), 1, 0, 0));
    vecs.push_back(mk(0, '0,        0, 0, 0, '0, DW'('h2F), 1, 1, 0));
  endtask

  // Request at k=0: addresses k=1..8, enables k=2..9, data k=3..10, half released after k=10.
  task automatic playback();
    for (int k = 0; k <= 12; k++) begin
      @(posedge Clk);
      #1;
      idleInputs();
      FrameReq = (k == 0);
      @(negedge Clk);
      if (k >= 1 && k <= 8) check($sformatf("pb[%0d] RamAddrB", k), RamAddrB, k - 1);
      check($sformatf("pb[%0d] RamEnB", k), RamEnB, (k >= 2 && k <= 9));
      check($sformatf("pb[%0d] RamWeB", k), RamWeB, 0);
      check($sformatf("pb[%0d] RdValid", k), RdValid, (k >= 3 && k <= 10));
      check($sformatf("pb[%0d] RdData", k), RdData, (k >= 3 && k <= 10) ? k - 2 : 0);
      check($sformatf("pb[%0d] RdLast", k), RdLast, (k == 10));
      check($sformatf("pb[%0d] FrameAvail", k), FrameAvail, (k <= 10));
    end
  endtask

  // Sample rate held at two in three cycles so each half fills slower than a frame plays out.
  task automatic pingpong();
    int wIdx = 0;
    int wChk = 0;
    int rChk = 0;
    logic [AB-1:0] prevA = '0;
    logic prevV = 1'b0;
    logic prevL = 1'b0;
    for (int c = 0; c < 150 && rChk < 24; c++) begin
      @(posedge Clk);
      #1;
      FrameReq    = 1'b1;
      OverrunClr  = 1'b0;
      SampleValid = (wIdx < 24) && (c % 3 != 2);
      SampleIn    = DW'('h100 + wIdx);
      if (SampleValid) wIdx++;
      @(negedge Clk);
      if (RamEnA) begin
        check($sformatf("pp write %0d addr", wChk), prevA, wChk % 16);
        check($sformatf("pp write %0d data", wChk), RamDinA, 'h100 + wChk);
        wChk++;
      end
      if (prevV && !prevL) check($sformatf("pp RdValid gap before %0d", rChk), RdValid, 1);
      if (RdValid) begin
        check($sformatf("pp read %0d data", rChk), RdData, 'h100 + rChk);
        check($sformatf("pp read %0d last", rChk), RdLast, (rChk % 8 == 7));
        rChk++;
      end
      prevA = RamAddrA;
      prevV = RdValid;
      prevL = RdLast;
    end
    check("pp reads done", rChk, 24);
    check("pp writes done", wChk, 24);
    check("pp Overrun", Overrun, 0);
    @(posedge Clk);
    #1;
    idleInputs();
  endtask

  task automatic resetMidPlay();
    for (int k = 0; k <= 4; k++) begin
      @(posedge Clk);
      #1;
      idleInputs();
      FrameReq = (k == 0);
      @(negedge Clk);
    end
    check("mid RamAddrB at cnt3", RamAddrB, 3);
    check("mid RdValid before reset", RdValid, 1);
    #1;
    Rst_n = 1'b0;
    #1;
    check("mid RdValid in reset", RdValid, 0);
    check("mid RdLast in reset", RdLast, 0);
    check("mid RdData in reset", RdData, 0);
    check("mid RamEnB in reset", RamEnB, 0);
    check("mid FrameAvail in reset", FrameAvail, 0);
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    SampleValid = 1'b1;
    SampleIn    = DW'('h55);
    FrameReq    = 1'b1;
    @(negedge Clk);
    check("mid post addrA", RamAddrA, 0);
    check("mid post FrameAvail", FrameAvail, 0);
    check("mid post RamEnA idle", RamEnA, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      #1;
      SampleValid = 1'b0;
      @(negedge Clk);
      if (k == 0) begin
        check("mid post RamEnA", RamEnA, 1);
        check("mid post RamDinA", RamDinA, 'h55);
      end
      check($sformatf("mid post[%0d] RamEnB", k), RamEnB, 0);
      check($sformatf("mid post[%0d] RdValid", k), RdValid, 0);
      check($sformatf("mid post[%0d] FrameAvail", k), FrameAvail, 0);
    end
    idleInputs();
  endtask

  initial begin
    Rst_n = 1'b0;
    idleInputs();

    doReset();
    buildFill();
    runTable("fill");
    playback();

    doReset();
    pingpong();

    doReset();
    buildOvr();
    runTable("ovr");

    doReset();
    buildFill();
    runTable("fill2");
    resetMidPlay();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
